instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Front end of the core: owns the PC, fetches 32-bit instructions from instruction memory with a req/ack handshake,
//  and presents each instruction with its opcode field (instr[6:0]) to the opcode control decoder and the datapath.
//  Consumes the resolved branch/jump outcome back from the datapath to select the next fetch address.
//  Only one instruction is in flight. There is no speculation and no prediction.
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1     single clock, all state on rising edge
//  reset          in   1     synchronous, active-high
//  imem_req       out  1     fetch request; held with imem_addr until imem_ack
//  imem_addr      out  XLEN  fetch address (word aligned)
//  imem_ack       in   1     memory returns imem_rdata this cycle
//  imem_rdata     in   XLEN  instruction word, valid only when imem_ack=1
//  instr          out  32    held instruction to decode/datapath
//  opcode         out  7     instr[6:0], drives the control decoder
//  instr_valid    out  1     instr/opcode/pc valid
//  instr_ready    in   1     downstream consumes instruction (retire handshake)
//  pc             out  XLEN  address of instr
//  pc_plus4       out  XLEN  pc + 4 (link value for JAL/JALR)
//  branch_taken   in   1     sampled only on retire; 1 = redirect to branch_target
//  branch_target  in   XLEN  redirect address
//  misalign_fault out  1     sticky; taken target with [1:0]!=0
//  instret        out  32    count of retired instructions
// BEHAVIOUR
//  - Retire event R = instr_valid & instr_ready. branch_taken/branch_target are ignored when R=0.
//  - FSM states: IDLE, REQ, HOLD, FAULT. Reset sets state IDLE.
//  - IDLE: a 1-cycle post-reset state. Go to REQ with fetch_pc = RESET_PC.
//  - REQ: imem_req=1 and imem_addr=fetch_pc, both stable until ack.
//    - On imem_ack: capture instr<=imem_rdata and pc<=fetch_pc, then go to HOLD.
//    - An ack in the first REQ cycle is legal, so the fastest path is REQ for 1 cycle.
//  - HOLD: instr_valid=1. instr, pc and opcode stay stable until R.
//    - On R with branch_taken=0: fetch_pc <= pc+4, go to REQ.
//    - On R with branch_taken=1 and target[1:0]==0: fetch_pc <= branch_target, go to REQ.
//    - On R with branch_taken=1 and target[1:0]!=0: set misalign_fault, go to FAULT.
//  - FAULT: terminal. imem_req=0 and instr_valid=0. Only reset leaves it.
//  - instr_valid and imem_req are never high in the same cycle.
//  - Latency: R at cycle t puts imem_req high at t+1. Ack at cycle u puts instr_valid high at u+1.
//  - Throughput: at best 1 instruction per 2 cycles (ack same cycle plus immediate ready).
//  - instret increments by 1 on each R, including the faulting branch. It wraps modulo 2^32.
//  - pc_plus4 is combinational pc+4, truncated to XLEN, so 0xFFFF_FFFC wraps to 0.
//    fetch_pc wraps the same way.
//  - imem_ack outside REQ is ignored (no capture, no state change).
//  - Reset mid-request: imem_req drops on the next edge. The outstanding request is abandoned and memory must tolerate it.
//  - Reset values of outputs:
//    - imem_req=0, imem_addr=RESET_PC, instr=32'h0000_0013 (NOP), opcode=7'h13, instr_valid=0
//    - pc=RESET_PC, pc_plus4=RESET_PC+4, misalign_fault=0, instret=0
// STRUCTURE
//  - Shared header rv_defines.vh holds:
//    - opcode constants OPC_LOAD=0000011, OPC_OPIMM=0010011, OPC_AUIPC=0010111, OPC_STORE=0100011
//    - opcode constants OPC_OP=0110011, OPC_LUI=0110111, OPC_BRANCH=1100011, OPC_JALR=1100111, OPC_JAL=1101111
//    - the NOP encoding and the FSM state encodings (IDLE=0, REQ=1, HOLD=2, FAULT=3)
//  - Sub-module pc_next_sel is combinational. It takes pc, branch_taken and branch_target.
//    It outputs next_pc and a misalign flag. All sequential logic stays in instr_fetch_unit.
// TESTING
//  1 Reset, then release with imem_ack tied 1:
//    - imem_req rises 1 cycle after IDLE with imem_addr=0x0
//    - instr_valid follows 1 cycle later with pc=0x0 and instret=0
//  2 Sequential stream with instr_ready=1 and no branch:
//    - addresses 0x0, 0x4, 0x8, 0xC are fetched
//    - instret=4 after four retires
//    - opcode equals rdata[6:0] each time
//  3 Retire with branch_taken=1, target=0x100:
//    - next imem_addr=0x100
//    - pc_plus4 during the branch equals branch pc+4
//  4 Backpressure: instr_ready=0 for 5 cycles:
//    - instr, pc and opcode stay stable
//    - imem_req stays 0
//    - exactly one retire when ready rises
//  5 Retire with branch_taken=1, target=0x102:
//    - misalign_fault=1 and FSM in FAULT
//    - no further imem_req
//    - instret incremented once
//    - reset clears everything
//  6 Reset during REQ with ack delayed 3 cycles:
//    - imem_req drops on the next edge
//    - a late imem_ack is ignored
//    - the restart fetch goes to RESET_PC

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: RV32 opcode constants,
// the NOP encoding and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

  localparam int IFU_XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } ifu_state_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory handshake, instruction presentation
// and branch-resolution signals; master is the fetch unit side.
interface instr_fetch_unit_if #(parameter int XLEN = 32);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            misalign_fault;
  logic [31:0]     instret;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4,
           misalign_fault, instret,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4,
           misalign_fault, instret,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );

endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// pc_next_sel: combinational choice of the next fetch address from the
// retiring pc and the resolved branch outcome, plus a misaligned-target flag.
module instr_fetch_unit_pc_next_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  // pc+4 wraps naturally at the top of the address space
  assign next_pc  = branch_taken ? branch_target : pc + XLEN'(4);
  assign misalign = branch_taken & (branch_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Core front end: owns the PC, fetches one instruction at a time over a
// req/ack handshake and holds it until downstream retires it.
//
//   state | meaning
//   IDLE  | one cycle after reset, loads fetch_pc with RESET_PC
//   REQ   | imem_req high with imem_addr=fetch_pc until imem_ack
//   HOLD  | instruction presented (instr_valid) until retired
//   FAULT | misaligned taken target seen; terminal until reset
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  instr_fetch_unit_if.master bus
);

  ifu_state_e state, state_next;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            fault_q;
  logic [31:0]     instret_q;

  logic            req_c;
  logic            valid_c;
  logic            capture;
  logic            retire;
  logic            fault_set;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  instr_fetch_unit_pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc            (pc_q),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .next_pc       (next_pc),
    .misalign      (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    valid_c    = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    fault_set  = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        req_c = 1'b1;
        if (bus.imem_ack) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        valid_c = 1'b1;
        if (bus.instr_ready) begin
          retire = 1'b1;
          if (misalign) begin
            fault_set  = 1'b1;
            state_next = ST_FAULT;
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      fault_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      if (state == ST_IDLE) fetch_pc <= RESET_PC;
      if (capture) begin
        instr_q <= bus.imem_rdata[31:0];
        pc_q    <= fetch_pc;
      end
      // the faulting branch still counts as retired
      if (retire) begin
        instret_q <= instret_q + 32'd1;
        if (fault_set) fault_q  <= 1'b1;
        else           fetch_pc <= next_pc;
      end
    end
  end

  assign bus.imem_req       = req_c;
  assign bus.imem_addr      = fetch_pc;
  assign bus.instr_valid    = valid_c;
  assign bus.instr          = instr_q;
  assign bus.opcode         = opcode_of(instr_q);
  assign bus.pc             = pc_q;
  assign bus.pc_plus4       = pc_q + XLEN'(4);
  assign bus.misalign_fault = fault_q;
  assign bus.instret        = instret_q;

endmodule
